mem_arbiter: RTL and testbench

//  Single-core memory controller between the cache block (icache/dcache) and the RAM.

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/mem_arb_pick.sv | 29 ++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM handshake state and memory arbiter state.
package cpu_types_pkg;
  parameter int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  // Encoding of the round-robin history bit: which requester completed last.
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between icache and dcache requests.
// MEM_ARB_RR_EN selects round-robin; otherwise dcache has fixed priority.
module mem_arb_pick
  import cpu_types_pkg::*;
(
  input  logic ireq,
  input  logic dreq,
  input  logic last_gnt,
  output logic gnt_i,
  output logic gnt_d
);

`ifdef MEM_ARB_RR_EN
  // On contention the requester that did not complete last goes first.
  always_comb begin
    gnt_d = dreq & (~ireq | (last_gnt == LAST_I));
    gnt_i = ireq & ~gnt_d;
  end
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;

  always_comb begin
    gnt_d = dreq;
    gnt_i = ireq & ~dreq;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: multiplexes icache and dcache requests onto the single RAM port.
// Optional macro MEM_ARB_RR_EN enables round-robin arbitration (default: dcache priority).
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              ram_err
);

  arb_state_t state, next_state;
  logic       dreq;
  logic       gnt_i, gnt_d;
  logic       last_gnt;

  assign dreq  = dREN | dWEN;
  assign iload = ramload;
  assign dload = ramload;

  mem_arb_pick u_pick (
    .ireq     (iREN),
    .dreq     (dreq),
    .last_gnt (last_gnt),
    .gnt_i    (gnt_i),
    .gnt_d    (gnt_d)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      ram_err <= 1'b0;
    end else begin
      state <= next_state;
      if (state != IDLE && ramstate == ERROR)
        ram_err <= 1'b1;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      last_gnt <= LAST_D;
    else if (state == GNT_I && !iwait)
      last_gnt <= LAST_I;
    else if (state == GNT_D && !dwait)
      last_gnt <= LAST_D;
  end
`else
  assign last_gnt = LAST_D;
`endif

  // A dropped enable releases the RAM immediately and returns to IDLE without a wait pulse.
  always_comb begin
    next_state = state;
    iwait      = 1'b1;
    dwait      = 1'b1;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    case (state)
      IDLE: begin
        if (gnt_d)
          next_state = GNT_D;
        else if (gnt_i)
          next_state = GNT_I;
      end
      GNT_I: begin
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == ACCESS) begin
            iwait      = 1'b0;
            next_state = IDLE;
          end
        end
      end
      GNT_D: begin
        if (!dreq) begin
          next_state = IDLE;
        end else begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (ramstate == ACCESS) begin
            dwait      = 1'b0;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; round-robin section runs only with MEM_ARB_RR_EN.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  ramstate_t   ramstate;
  logic        iwait, dwait, ramREN, ramWEN, ram_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int fails  = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .ram_err  (ram_err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic i_ren, input logic [31:0] i_a,
                               input logic d_ren, input logic d_wen,
                               input logic [31:0] d_a, input logic [31:0] d_st,
                               input ramstate_t rs);
    iREN     = i_ren;
    iaddr    = i_a;
    dREN     = d_ren;
    dWEN     = d_wen;
    daddr    = d_a;
    dstore   = d_st;
    ramstate = rs;
    #1;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST    = 1'b0;
    ramload = 32'h2402000A;
    applyStimulus(0, 0, 0, 0, 0, 0, FREE);
    checkOutput("rst_iwait", {31'd0, iwait}, 32'd1);
    checkOutput("rst_dwait", {31'd0, dwait}, 32'd1);
    checkOutput("rst_ramREN", {31'd0, ramREN}, 32'd0);
    checkOutput("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    checkOutput("rst_ramaddr", ramaddr, 32'd0);
    checkOutput("rst_ramstore", ramstore, 32'd0);
    checkOutput("rst_ram_err", {31'd0, ram_err}, 32'd0);
    #10 nRST = 1'b1;
    step();

    // Instruction fetch: FREE in the arbitration cycle, ACCESS in the grant cycle.
    applyStimulus(1, 32'h40, 0, 0, 0, 0, FREE);
    checkOutput("t1_idle_iwait", {31'd0, iwait}, 32'd1);
    checkOutput("t1_idle_ramREN", {31'd0, ramREN}, 32'd0);
    step();
    applyStimulus(1, 32'h40, 0, 0, 0, 0, ACCESS);
    checkOutput("t1_ramaddr", ramaddr, 32'h40);
    checkOutput("t1_ramREN", {31'd0, ramREN}, 32'd1);
    checkOutput("t1_iwait", {31'd0, iwait}, 32'd0);
    checkOutput("t1_iload", iload, 32'h2402000A);
    step();
    checkOutput("t1_pulse_once", {31'd0, iwait}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, FREE);
    step();

    // Simultaneous requests: dcache first, then icache after one IDLE cycle.
    applyStimulus(1, 32'h100, 1, 0, 32'h200, 0, FREE);
    step();
    applyStimulus(1, 32'h100, 1, 0, 32'h200, 0, ACCESS);
    checkOutput("t2_d_ramaddr", ramaddr, 32'h200);
    checkOutput("t2_dwait", {31'd0, dwait}, 32'd0);
    checkOutput("t2_iwait_held", {31'd0, iwait}, 32'd1);
    step();
    applyStimulus(1, 32'h100, 0, 0, 32'h200, 0, FREE);
    checkOutput("t2_gap_ramREN", {31'd0, ramREN}, 32'd0);
    checkOutput("t2_gap_iwait", {31'd0, iwait}, 32'd1);
    step();
    applyStimulus(1, 32'h100, 0, 0, 32'h200, 0, ACCESS);
    checkOutput("t2_i_ramaddr", ramaddr, 32'h100);
    checkOutput("t2_iwait", {31'd0, iwait}, 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE);
    step();

    // Write wins over read when both enables are high.
    applyStimulus(0, 0, 1, 1, 32'h80, 32'hDEADBEEF, FREE);
    step();
    applyStimulus(0, 0, 1, 1, 32'h80, 32'hDEADBEEF, BUSY);
    checkOutput("t3_ramWEN", {31'd0, ramWEN}, 32'd1);
    checkOutput("t3_ramREN", {31'd0, ramREN}, 32'd0);
    checkOutput("t3_ramstore", ramstore, 32'hDEADBEEF);
    checkOutput("t3_ramaddr", ramaddr, 32'h80);
    checkOutput("t3_busy_dwait", {31'd0, dwait}, 32'd1);
    applyStimulus(0, 0, 1, 1, 32'h80, 32'hDEADBEEF, ACCESS);
    checkOutput("t3_dwait", {31'd0, dwait}, 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE);
    step();

    // Five BUSY cycles then ACCESS: address held, wait released only on ACCESS.
    applyStimulus(0, 0, 1, 0, 32'h1234, 0, FREE);
    step();
    applyStimulus(0, 0, 1, 0, 32'h1234, 0, BUSY);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t4_busy%0d_ramaddr", i), ramaddr, 32'h1234);
      checkOutput($sformatf("t4_busy%0d_dwait", i), {31'd0, dwait}, 32'd1);
      step();
    end
    applyStimulus(0, 0, 1, 0, 32'h1234, 0, ACCESS);
    checkOutput("t4_access_ramaddr", ramaddr, 32'h1234);
    checkOutput("t4_access_dwait", {31'd0, dwait}, 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE);
    step();

    // One ERROR cycle sets the sticky flag; the retry completes afterwards.
    applyStimulus(1, 32'h44, 0, 0, 0, 0, FREE);
    step();
    applyStimulus(1, 32'h44, 0, 0, 0, 0, ERROR);
    checkOutput("t5_err_iwait", {31'd0, iwait}, 32'd1);
    checkOutput("t5_err_before", {31'd0, ram_err}, 32'd0);
    step();
    applyStimulus(1, 32'h44, 0, 0, 0, 0, ACCESS);
    checkOutput("t5_ram_err", {31'd0, ram_err}, 32'd1);
    checkOutput("t5_retry_ramaddr", ramaddr, 32'h44);
    checkOutput("t5_iwait", {31'd0, iwait}, 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE);
    step();
    checkOutput("t5_err_sticky", {31'd0, ram_err}, 32'd1);

    // Requester withdraws while granted: enables drop, no wait pulse.
    applyStimulus(1, 32'h48, 0, 0, 0, 0, FREE);
    step();
    applyStimulus(0, 32'h48, 0, 0, 0, 0, ACCESS);
    checkOutput("drop_ramREN", {31'd0, ramREN}, 32'd0);
    checkOutput("drop_iwait", {31'd0, iwait}, 32'd1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE);

    // Reset asserted in the middle of a dcache grant.
    applyStimulus(0, 0, 1, 0, 32'h300, 0, FREE);
    step();
    applyStimulus(0, 0, 1, 0, 32'h300, 0, BUSY);
    checkOutput("t6_pre_ramREN", {31'd0, ramREN}, 32'd1);
    nRST = 1'b0;
    #1;
    checkOutput("t6_rst_ramREN", {31'd0, ramREN}, 32'd0);
    checkOutput("t6_rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    checkOutput("t6_rst_dwait", {31'd0, dwait}, 32'd1);
    checkOutput("t6_rst_iwait", {31'd0, iwait}, 32'd1);
    checkOutput("t6_rst_err", {31'd0, ram_err}, 32'd0);
    #1 nRST = 1'b1;
    applyStimulus(0, 0, 1, 0, 32'h300, 0, ACCESS);
    checkOutput("t6_idle_dwait", {31'd0, dwait}, 32'd1);
    step();
    checkOutput("t6_regrant_ramaddr", ramaddr, 32'h300);
    checkOutput("t6_regrant_dwait", {31'd0, dwait}, 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE);
    step();

`ifdef MEM_ARB_RR_EN
    // An icache-only access first, so contention then alternates D,I,D,I.
    applyStimulus(1, 32'h500, 0, 0, 32'h600, 0, FREE);
    step();
    applyStimulus(1, 32'h500, 0, 0, 32'h600, 0, ACCESS);
    step();
    applyStimulus(1, 32'h500, 1, 0, 32'h600, 0, ACCESS);
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput($sformatf("rr%0d_ramaddr", k), ramaddr, (k % 2 == 0) ? 32'h600 : 32'h500);
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, FREE);
    step();
`endif

    $display("[TB] %0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
